// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline types: the queued instruction entry, the
// outstanding-read tag, and the bubble instruction.
package pipe_pkg;

  localparam int PKG_AW = 32;
  localparam int PKG_DW = 32;

  localparam logic [PKG_DW-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [PKG_DW-1:0] instr;
    logic [PKG_AW-1:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic              valid;
    logic              epoch;
    logic [PKG_AW-1:0] pc;
  } inflight_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; push and pop may coincide when full.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rdata   = mem[rd_ptr];
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues imem reads for PC addresses, queues
// returned words, and feeds the IF/ID register with a zero-bubble bypass.
module fetch_queue #(
  parameter int               DEPTH = 4,
  parameter int               AW    = pipe_pkg::PKG_AW,
  parameter int               DW    = pipe_pkg::PKG_DW,
  parameter logic [DW-1:0]    NOP   = pipe_pkg::NOP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_addr,
  input  logic          pc_refresh,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          id_stall,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  output logic          if_valid,
  output logic          fetch_hold
);

  import pipe_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          unused_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          bypass;
  logic          accept;
  logic          resp_ok;
  logic          epoch;
  inflight_t     inflight;
  fetch_entry_t  resp;
  fetch_entry_t  head;

  // Credit only what is already queued or outstanding; same-cycle pops are ignored.
  assign occupancy  = {1'b0, count} + (CW+1)'(inflight.valid);
  assign accept     = pc_refresh | (occupancy < (CW+1)'(DEPTH));
  assign imem_req   = reset & accept;
  assign imem_addr  = pc_addr;
  assign fetch_hold = reset & ~accept;

  assign resp_ok   = inflight.valid & (inflight.epoch == epoch);
  assign resp      = '{instr: imem_rdata, pc: inflight.pc};
  assign bypass    = ~id_stall & fifo_empty;
  assign fifo_pop  = ~id_stall & ~fifo_empty;
  assign fifo_push = resp_ok & ~bypass;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (pc_refresh),
    .wdata (resp),
    .rdata (head),
    .count (count),
    .full  (unused_full),
    .empty (fifo_empty)
  );

  // A flush retags the target request with the new epoch and bubbles IF/ID,
  // regardless of a decode stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      epoch    <= 1'b0;
      if_instr <= NOP;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else begin
      inflight <= '{valid: accept, epoch: epoch ^ pc_refresh, pc: pc_addr};
      epoch    <= epoch ^ pc_refresh;
      if (pc_refresh) begin
        if_instr <= NOP;
        if_valid <= 1'b0;
      end else if (!id_stall) begin
        if (!fifo_empty) begin
          if_instr <= head.instr;
          if_pc    <= head.pc;
          if_valid <= 1'b1;
        end else if (resp_ok) begin
          if_instr <= resp.instr;
          if_pc    <= resp.pc;
          if_valid <= 1'b1;
        end else begin
          if_instr <= NOP;
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-level model of in-order fetch
// with flush, checked each cycle under directed and random PC/stall traffic.
module tb_fetch_queue;

  import pipe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_addr = '0;
  logic        pc_refresh = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        id_stall = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        fetch_hold;

  int checks = 0;
  int errors = 0;

  logic [31:0] readyQ[$];
  bit          pendValid;
  logic [31:0] pendPc;
  bit          expValid;
  logic [31:0] expPc;
  logic [31:0] expInstr;
  logic [31:0] pcNext;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_addr    (pc_addr),
    .pc_refresh (pc_refresh),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .fetch_hold (fetch_hold)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2008_0005;
      32'd1:   return 32'h2009_0003;
      32'd2:   return 32'h0109_5020;
      32'd3:   return 32'hAC0A_0000;
      default: return a * 32'h9E37_79B1 + 32'h0135_7BDF;
    endcase
  endfunction

  // Synchronous instruction memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= memWord(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    readyQ.delete();
    pendValid = 1'b0;
    pendPc    = '0;
    expValid  = 1'b0;
    expPc     = '0;
    expInstr  = NOP;
    pcNext    = '0;
  endtask

  // Program-order view: everything accepted and not flushed reaches IF/ID in
  // order, at the earliest one edge after acceptance.
  task automatic modelEdge(input bit refresh, input logic [31:0] addr, input bit stall, input bit acc);
    logic [31:0] avail[$];
    if (refresh) begin
      readyQ.delete();
      expValid = 1'b0;
      expInstr = NOP;
    end else begin
      avail = readyQ;
      if (pendValid) avail.push_back(pendPc);
      if (!stall) begin
        if (avail.size() > 0) begin
          expPc    = avail.pop_front();
          expValid = 1'b1;
          expInstr = memWord(expPc);
        end else begin
          expValid = 1'b0;
          expInstr = NOP;
        end
      end
      readyQ = avail;
    end
    pendValid = acc;
    pendPc    = addr;
  endtask

  // One cycle, entered just after a falling edge.
  task automatic applyStimulus(input bit refresh, input logic [31:0] target, input bit stall);
    bit acc;
    pc_refresh = refresh;
    pc_addr    = refresh ? target : pcNext;
    id_stall   = stall;
    #1;
    acc = refresh || (readyQ.size() + int'(pendValid) < DEPTH);
    checkOutput("imem_req", imem_req, acc);
    checkOutput("fetch_hold", fetch_hold, !acc);
    checkOutput("imem_addr", imem_addr, pc_addr);
    @(posedge clk);
    modelEdge(refresh, pc_addr, stall, acc);
    if (acc) pcNext = pc_addr + 1;
    @(negedge clk);
    checkOutput("if_valid", if_valid, expValid);
    if (expValid) checkOutput("if_pc", if_pc, expPc);
    checkOutput("if_instr", if_instr, expInstr);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_if_valid", if_valid, 1'b0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_instr", if_instr, NOP);
    checkOutput("rst_imem_req", imem_req, 1'b0);
    checkOutput("rst_fetch_hold", fetch_hold, 1'b0);
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    checkResetOutputs();
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] sequential stream");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] stall hold and drain");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] flush with queued work");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] flush under stall");
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] back-to-back flushes");
    applyStimulus(1'b1, 32'h10, 1'b0);
    applyStimulus(1'b1, 32'h20, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    pc_refresh = 1'b0;
    id_stall   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs();
    modelReset();
    pc_addr = '0;
    @(negedge clk);
    checkResetOutputs();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, 32'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
